// File: rtl/vote_collector.sv
`default_nettype none
// ============================================================================
// Module      : vote_collector
// Description : Ballot front end for the 4-voter majority decision path.
//               A session opens on start, latches one vote per voter (first
//               valid vote wins) and closes when all four voters have voted
//               or TIMEOUT OPEN cycles have elapsed. The ballot and a one-hot
//               verdict are then offered on a valid/ready handshake.
// Ports       : clk, rst            - clock / synchronous active-high reset
//               start               - session open request (IDLE only)
//               vote_yes, vote_no   - per-voter vote pulses, bit i = voter i
//               busy                - high in OPEN and REPORT
//               voted               - voters whose vote has been latched
//               ballot              - latched votes, 1 = yes
//               result              - 001 fail, 010 tie, 100 pass
//               out_valid/out_ready - output handshake
// Revision    : 1.0 - initial release
// ============================================================================
module vote_collector #(
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] vote_yes,
    input  logic [3:0] vote_no,
    output logic       busy,
    output logic [3:0] voted,
    output logic [3:0] ballot,
    output logic [2:0] result,
    output logic       out_valid,
    input  logic       out_ready
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_OPEN   = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [3:0]       r_voted;
    logic [3:0]       r_ballot;
    logic [2:0]       r_result;
    logic             r_out_valid;

    logic [3:0]       w_take;
    logic [3:0]       w_voted_nxt;
    logic [3:0]       w_ballot_nxt;
    logic [2:0]       w_yes_cnt;
    logic [2:0]       w_verdict;
    logic             w_close;

    // A vote is taken only from a voter that has not voted yet and only when
    // exactly one of yes/no is asserted; yes+no together is discarded.
    always_comb begin
        w_take       = ~r_voted & (vote_yes ^ vote_no);
        w_voted_nxt  = r_voted | w_take;
        w_ballot_nxt = (r_ballot & ~w_take) | (w_take & vote_yes);
        w_yes_cnt    = {2'b00, w_ballot_nxt[0]} + {2'b00, w_ballot_nxt[1]}
                     + {2'b00, w_ballot_nxt[2]} + {2'b00, w_ballot_nxt[3]};
        if (w_yes_cnt <= 3'd1) begin
            w_verdict = 3'b001;
        end else if (w_yes_cnt == 3'd2) begin
            w_verdict = 3'b010;
        end else begin
            w_verdict = 3'b100;
        end
        // Close decision uses the vote set including this cycle's pulses.
        w_close = (&w_voted_nxt) || (r_cnt == c_CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_voted     <= 4'b0000;
            r_ballot    <= 4'b0000;
            r_result    <= 3'b000;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state  <= S_OPEN;
                        r_busy   <= 1'b1;
                        r_voted  <= 4'b0000;
                        r_ballot <= 4'b0000;
                        r_cnt    <= '0;
                    end
                end
                S_OPEN: begin
                    r_voted  <= w_voted_nxt;
                    r_ballot <= w_ballot_nxt;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_close) begin
                        r_state     <= S_REPORT;
                        r_result    <= w_verdict;
                        r_out_valid <= 1'b1;
                    end
                end
                S_REPORT: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign voted     = r_voted;
    assign ballot    = r_ballot;
    assign result    = r_result;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: doc/vote_collector.md
Name: vote_collector

Overview:
- Ballot front end for the 4-voter majority decision path; produces the 4-bit vote vector the majority logic consumes.
- Opens a voting session on `start` and latches one vote per voter, first vote wins.
- Closes the session when all four voters have voted or a timeout expires; unvoted voters count as "no".
- Presents the ballot and the one-hot verdict over a valid/ready handshake.

Parameters:
- TIMEOUT, 1000: number of OPEN-state cycles before forced close; legal range 2..65535.
- CNT_W, 16: width of the timeout counter; must satisfy 2^CNT_W >= TIMEOUT.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  session open request; honoured only in IDLE.
- vote_yes  in  4  per-voter "yes" pulse; bit i = voter i.
- vote_no  in  4  per-voter "no" pulse; bit i = voter i.
- busy  out  1  high in OPEN and REPORT.
- voted  out  4  bit i set once voter i's vote is latched; timed-out voters are not set.
- ballot  out  4  latched votes, 1 = yes; bit layout matches the majority block input.
- result  out  3  one-hot verdict: 3'b001 = fail (0-1 yes), 3'b010 = tie (2 yes), 3'b100 = pass (3-4 yes).
- out_valid  out  1  ballot/result valid.
- out_ready  in  1  consumer accepts.

Behaviour:
- Reset: synchronous, active-high.
  - Sets state IDLE.
  - Clears busy, voted, ballot, result (3'b000), out_valid and the counter.
  - Reset in any state, including mid-session or mid-handshake, aborts the session with no output.
- Registers: all outputs are registered; no combinational input-to-output path.
- FSM states: IDLE, OPEN, REPORT.
- IDLE:
  - busy = 0, out_valid = 0; ballot/result hold the last reported values.
  - start = 1 at edge k: state OPEN at k; voted, ballot and counter cleared at k; busy = 1 after k.
- OPEN:
  - Per voter i with voted[i] = 0, at each edge:
    - vote_yes[i] & ~vote_no[i]: voted[i] <= 1, ballot[i] <= 1.
    - vote_no[i] & ~vote_yes[i]: voted[i] <= 1, ballot[i] <= 0.
    - Both high: invalid, ignored; voter may vote again later.
    - Neither high: no change.
  - Voters with voted[i] = 1 are ignored; no vote changes are allowed.
  - Multiple voters may vote in the same cycle.
  - Counter increments by 1 every OPEN cycle.
  - Close condition, evaluated at edge k using the post-update vote set: all four voted, or counter == TIMEOUT-1.
    - Votes sampled at edge k are always included before close.
    - On close: state REPORT at edge k, out_valid = 1 and result = verdict of the final ballot, both visible after edge k.
    - Latency: the last vote pulse is sampled at edge k and out_valid is high in cycle k+1.
  - Timeout: unvoted bits stay ballot = 0 and voted = 0. A session with no votes reports ballot 4'b0000, result 3'b001.
  - start in OPEN is ignored.
- REPORT:
  - out_valid = 1; ballot, result and voted are held stable until accepted.
  - Vote pulses and start are ignored.
  - out_valid & out_ready at edge k: state IDLE, out_valid = 0, busy = 0 at k.
  - start in the same cycle as acceptance is ignored; a new session needs start in a later IDLE cycle.
- Verdict arithmetic: yes count = popcount(ballot), 3 bits, range 0..4.
  - count <= 1: 3'b001.
  - count == 2: 3'b010.
  - count >= 3: 3'b100.
  - result is never 3'b000 outside reset.
- Counter wrap: the counter never wraps, because the session closes at TIMEOUT-1.

Test Plan:
- Reset, start at cycle 1, single-cycle pulses vote_yes = 4'b1011 and vote_no = 4'b0100 together at cycle 3 -> out_valid high at cycle 4, ballot = 4'b1011, voted = 4'b1111, result = 3'b100; out_ready at cycle 6 -> out_valid low and busy low at cycle 7.
- Staggered votes yes0, no1, yes2, no3 on separate cycles, plus a repeat no0 -> ballot = 4'b0101, result = 3'b010; the repeat is ignored.
- Voter 2 asserts yes and no in the same cycle, then no alone later; others vote yes -> ballot = 4'b1011, result = 3'b100.
- TIMEOUT = 8, only voter 1 votes yes -> out_valid exactly 8 OPEN cycles after start, voted = 4'b0010, ballot = 4'b0010, result = 3'b001.
- Hold out_ready = 0 for 20 cycles in REPORT while toggling votes and start -> ballot/result unchanged; start pulsed together with acceptance -> stays IDLE.
- Assert rst in OPEN after two votes -> next cycle IDLE, busy = 0, voted = 0, ballot = 0, result = 3'b000, out_valid = 0.
